// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin hold arbiter.
//   req       : level request vector, bit i = requester i
//   gnt       : registered one-hot grant, zero when idle
//   gnt_id    : encoded owner index, 0 when no grant
//   gnt_valid : high while any grant bit is set
//   hold_cnt  : cycles the current owner has held the grant (1-based), 0 when idle
// master = requester side, slave = arbiter side.
interface rr_hold_arbiter_if #(
  parameter int N = 4
) ();
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic [7:0]     hold_cnt;

  modport master (
    output req,
    input  gnt, gnt_id, gnt_valid, hold_cnt
  );

  modport slave (
    input  req,
    output gnt, gnt_id, gnt_valid, hold_cnt
  );
endinterface

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold. The owner keeps the grant while its
// request stays high; once it has held for MAX_HOLD cycles and someone else
// is waiting, the grant is forced onward. A rotating pointer (one past the
// last released owner) sets the scan start so nobody starves.
// Ports:
//   clk_i   : clock, all state on rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : rr_hold_arbiter_if.slave (req in; gnt, gnt_id, gnt_valid, hold_cnt out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; first request seen is granted from the pointer
// BUSY  | one owner holds the grant; release/hold/forced-release logic
module rr_hold_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  rr_hold_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N);
  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q,   ptr_d;
  logic [IDW-1:0] own_q,   own_d;
  logic [7:0]     hold_q,  hold_d;
  logic [N-1:0]   gnt_q,   gnt_d;
  logic [N-1:0]   others;

  // First set bit of r scanning p, p+1, ... with wrap modulo N.
  function automatic logic [IDW-1:0] sel(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0] res;
    logic           found;
    int             idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(p) + k) % N;
      if (!found && r[idx]) begin
        res   = IDW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] o);
    return (o == IDW'(N - 1)) ? '0 : o + IDW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    hold_d  = hold_q;
    // The owner's own bit never counts as a competitor, so a releasing owner
    // cannot win back the grant on the very edge it lets go.
    others  = bus.req & ~gnt_q;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          own_d   = sel(bus.req, ptr_q);
          hold_d  = 8'd1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!bus.req[own_q]) begin
          ptr_d = nxt(own_q);
          if (|others) begin
            own_d  = sel(others, nxt(own_q));
            hold_d = 8'd1;
          end else begin
            own_d   = '0;
            hold_d  = 8'd0;
            state_d = IDLE;
          end
        end else if (hold_q < MAX_HOLD_C) begin
          hold_d = hold_q + 8'd1;
        end else if (|others) begin
          ptr_d  = nxt(own_q);
          own_d  = sel(others, nxt(own_q));
          hold_d = 8'd1;
        end else begin
          // Sole requester at the limit: keep the grant, restart the count.
          hold_d = 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d = (state_d == BUSY) ? (N'(1) << own_d) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      hold_q  <= 8'd0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = own_q;
  assign bus.gnt_valid = (state_q == BUSY);
  assign bus.hold_cnt  = hold_q;
endmodule
